// File: rtl/conf_int_add__accum__w_ff.sv
// Frame accumulator behind the configurable-accuracy adder. It sums ACCUM_LEN samples
// and tags each frame result with its accuracy mode and a mixed-mode error flag.
module conf_int_add__accum__w_ff #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int ACCUM_LEN          = 4,
  localparam int DPW   = DATA_PATH_BITWIDTH,
  localparam int CNT_W = (ACCUM_LEN > 1) ? $clog2(ACCUM_LEN) : 1,
  localparam int OUT_W = DPW + 1 + $clog2(ACCUM_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DPW:0]     in_data,
  input  logic             in_acc__sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_acc__sel,
  output logic             out_mode_err
);

  // OP_BITWIDTH only travels with the adder configuration; the masked width is fixed.
  localparam int MASK_W = (OP_BITWIDTH > 0) ? 8 : 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCUM_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;

  logic [DPW:0]     sample;
  logic [OUT_W-1:0] sum;
  logic             first, last, xfer_in, mode_n, err_n;

  assign in_ready     = (state_q != HOLD);
  assign xfer_in      = in_valid & in_ready;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_acc__sel = out_sel_q;
  assign out_mode_err = out_err_q;

  always_comb begin
    // Approximate-mode results carry garbage in the low byte; drop it here.
    sample = in_data;
    if (!in_acc__sel) sample[MASK_W-1:0] = '0;

    first  = (state_q == IDLE);
    sum    = first ? OUT_W'(sample) : acc_q + OUT_W'(sample);
    mode_n = first ? in_acc__sel : mode_q;
    err_n  = first ? 1'b0 : (err_q | (in_acc__sel != mode_q));
    last   = first ? (ACCUM_LEN == 1) : (cnt_q == LAST_CNT);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (xfer_in) begin
          acc_d  = sum;
          mode_d = mode_n;
          err_d  = err_n;
          if (last) begin
            out_data_d  = sum;
            out_sel_d   = mode_n;
            out_err_d   = err_n;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
